// File: rtl/alu_cmd_driver.sv
// Command-side master for the combinational ALU: owns the accumulator, drives the
// ALU inputs for a settle window, writes the result back and returns it as a response.
module alu_cmd_driver #(
    parameter int WIDTH   = 16,
    parameter int OPW     = 3,
    parameter int NUM_OPS = 6,
    parameter int SETTLE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_bus,
    output logic [WIDTH-1:0] alu_ac,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] ac_out,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // rsp_data/rsp_err hold steady while rsp_valid=1 and rsp_ready=0.

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]  CNT_INIT  = CW'(SETTLE - 1);
    localparam logic [OPW:0]   NUM_OPS_W = (OPW + 1)'(NUM_OPS);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic [WIDTH-1:0] alu_ac_q, alu_ac_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_illegal;

    assign op_illegal = ({1'b0, cmd_op} >= NUM_OPS_W);

    always_comb begin
        state_d    = state_q;
        ac_d       = ac_q;
        bus_d      = bus_q;
        alu_ac_d   = alu_ac_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        ac_d       = cmd_data;
                        rsp_data_d = cmd_data;
                        rsp_err_d  = 1'b0;
                        state_d    = RESP;
                    end else if (op_illegal) begin
                        rsp_data_d = ac_q;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end else begin
                        bus_d    = cmd_data;
                        alu_ac_d = ac_q;
                        op_d     = cmd_op;
                        cnt_d    = CNT_INIT;
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    ac_d       = alu_result;
                    rsp_data_d = alu_result;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ac_q       <= '0;
            bus_q      <= '0;
            alu_ac_q   <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ac_q       <= ac_d;
            bus_q      <= bus_d;
            alu_ac_q   <= alu_ac_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign alu_bus   = bus_q;
    assign alu_ac    = alu_ac_q;
    assign alu_op    = op_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign ac_out    = ac_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver (SETTLE=3) with a small behavioural ALU for ops 0..5.
module tb_alu_cmd_driver;

    localparam int WIDTH = 16;
    localparam int OPW   = 3;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [OPW-1:0]   cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] alu_bus;
    logic [WIDTH-1:0] alu_ac;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [WIDTH-1:0] ac_out;
    logic             busy;

    int n_vec;
    int n_err;

    alu_cmd_driver #(.WIDTH(WIDTH), .OPW(OPW), .NUM_OPS(6), .SETTLE(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .alu_bus    (alu_bus),
        .alu_ac     (alu_ac),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .ac_out     (ac_out),
        .busy       (busy)
    );

    // Behavioural ALU: 0 add, 1 AC-bus, 2 and, 3 or, 4 xor, 5 AC+1.
    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_ac + alu_bus;
            3'd1:    alu_result = alu_ac - alu_bus;
            3'd2:    alu_result = alu_ac & alu_bus;
            3'd3:    alu_result = alu_ac | alu_bus;
            3'd4:    alu_result = alu_ac ^ alu_bus;
            3'd5:    alu_result = alu_ac + 16'd1;
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic load, input logic [OPW-1:0] op, input logic [WIDTH-1:0] data);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = load;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, rsp_valid, 1);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] data);
        accept(1'b1, 3'd0, data);
        check("load_rsp_valid", rsp_valid, 1);
        check("load_rsp_data", rsp_data, data);
        check("load_rsp_err", rsp_err, 0);
        check("load_ac", ac_out, data);
        consume("load");
    endtask

    logic [WIDTH-1:0] exp_tab [6];

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_tab[0] = 16'd7;
        exp_tab[1] = 16'd3;
        exp_tab[2] = 16'd0;
        exp_tab[3] = 16'd7;
        exp_tab[4] = 16'd7;
        exp_tab[5] = 16'd6;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;

        // Reset values
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ac", ac_out, 0);
        check("rst_alu_bus", alu_bus, 0);
        check("rst_alu_ac", alu_ac, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Load 5
        do_load(16'd5);

        // SETTLE=3 latency with rsp_ready held high: 5+3 = 8
        @(negedge clk);
        rsp_ready = 1'b1;
        accept(1'b0, 3'd0, 16'd3);
        check("lat_k_rsp_valid", rsp_valid, 0);
        check("lat_k_cmd_ready", cmd_ready, 0);
        check("lat_k_busy", busy, 1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check("lat_cmd_ready", cmd_ready, 0);
            check($sformatf("lat_rsp_valid_%0d", i), rsp_valid, (i == 3) ? 1 : 0);
        end
        check("lat_rsp_data", rsp_data, 16'd8);
        check("lat_ac", ac_out, 16'd8);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("lat_r_cmd_ready", cmd_ready, 1);
        check("lat_r_rsp_valid", rsp_valid, 0);
        check("lat_r_busy", busy, 0);

        // Ops 0..5 with bus=2, AC reloaded to 5
        for (int op = 0; op < 6; op++) begin
            do_load(16'd5);
            accept(1'b0, OPW'(op), 16'd2);
            check("op_exec_cmd_ready", cmd_ready, 0);
            check("op_exec_alu_bus", alu_bus, 16'd2);
            check("op_exec_alu_ac", alu_ac, 16'd5);
            check("op_exec_alu_op", alu_op, op);
            wait_rsp("op_rsp_timeout");
            check($sformatf("op%0d_rsp_data", op), rsp_data, exp_tab[op]);
            check($sformatf("op%0d_ac", op), ac_out, exp_tab[op]);
            check("op_rsp_err", rsp_err, 0);
            consume("op");
        end

        // Load leaves ALU inputs alone; illegal op 6 returns AC with error
        do_load(16'd5);
        check("load_keeps_alu_op", alu_op, 5);
        check("load_keeps_alu_bus", alu_bus, 16'd2);
        accept(1'b0, 3'd6, 16'd9);
        check("ill_rsp_valid", rsp_valid, 1);
        check("ill_rsp_err", rsp_err, 1);
        check("ill_rsp_data", rsp_data, 16'd5);
        check("ill_ac", ac_out, 16'd5);
        check("ill_alu_op", alu_op, 5);
        check("ill_alu_bus", alu_bus, 16'd2);
        consume("ill");
        accept(1'b0, 3'd7, 16'd1);
        check("ill7_rsp_err", rsp_err, 1);
        check("ill7_ac", ac_out, 16'd5);
        consume("ill7");

        // Backpressure: hold rsp_ready low 5 cycles, cmd_valid pulse ignored
        accept(1'b0, 3'd0, 16'd2);
        wait_rsp("bp_rsp_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = (i == 2);
            cmd_load  = 1'b1;
            cmd_data  = 16'h0055;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, 16'd7);
            check("bp_rsp_err", rsp_err, 0);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_ac", ac_out, 16'd7);
        consume("bp");
        @(negedge clk);
        check("bp_no_ghost", busy, 0);

        // Chained ops: 5+2=7, then 7+2=9
        do_load(16'd5);
        accept(1'b0, 3'd0, 16'd2);
        wait_rsp("ch1_timeout");
        check("ch1_rsp_data", rsp_data, 16'd7);
        consume("ch1");
        accept(1'b0, 3'd0, 16'd2);
        check("ch2_alu_ac", alu_ac, 16'd7);
        wait_rsp("ch2_timeout");
        check("ch2_rsp_data", rsp_data, 16'd9);
        consume("ch2");

        // Reset during EXEC
        accept(1'b0, 3'd3, 16'hf0f0);
        check("ar_busy_pre", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_cmd_ready", cmd_ready, 1);
        check("ar_rsp_valid", rsp_valid, 0);
        check("ar_ac", ac_out, 0);
        check("ar_alu_bus", alu_bus, 0);
        check("ar_alu_ac", alu_ac, 0);
        check("ar_alu_op", alu_op, 0);
        check("ar_rsp_data", rsp_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ar_no_rsp", rsp_valid, 0);
        end
        do_load(16'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side master for the 16-bit ALU. It accepts operation commands over a valid/ready handshake and owns the accumulator (AC) register. For each command it drives the ALU's bus, AC and operation inputs, holds them stable for a settle window, then writes the sampled result back into AC. It returns each result over a second valid/ready handshake. It sits between the control/sequencing logic of a core and the combinational `alu`.

## Interface
Parameters:
- WIDTH, 16, datapath width (bus, AC, result)
- OPW, 3, operation code width
- NUM_OPS, 6, number of legal op codes (0..NUM_OPS-1); must be ≤ 2^OPW
- SETTLE, 1, cycles ALU inputs are held before the result is sampled; must be ≥ 1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver can accept a command
- cmd_load  in  1  1: load AC with cmd_data directly (no ALU op); 0: ALU op
- cmd_op  in  OPW  ALU operation code
- cmd_data  in  WIDTH  bus operand
- alu_bus  out  WIDTH  to ALU in_bus
- alu_ac  out  WIDTH  to ALU in_AC
- alu_op  out  OPW  to ALU operation
- alu_result  in  WIDTH  from ALU data_out (combinational)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WIDTH  result (new AC value)
- rsp_err  out  1  1 = illegal op, AC unchanged
- ac_out  out  WIDTH  current AC register
- busy  out  1  state ≠ IDLE

## Operation
- Reset (rst_n low, asynchronous): state IDLE; AC, alu_bus, alu_ac, alu_op, rsp_data = 0; rsp_valid, rsp_err, busy = 0; settle counter = 0. cmd_ready is decoded from IDLE and therefore reads 1 during reset. A handshake while rst_n is low has no effect.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1. A command is accepted on a rising edge with cmd_valid & cmd_ready.
  - If cmd_load=1: AC←cmd_data, rsp_data←cmd_data, rsp_err←0, go to RESP. alu_* outputs are unchanged.
  - If cmd_load=0 and cmd_op ≥ NUM_OPS: rsp_data←AC, rsp_err←1, go to RESP. AC and alu_* are unchanged.
  - Otherwise: alu_bus←cmd_data, alu_ac←AC, alu_op←cmd_op, counter←SETTLE-1, go to EXEC.
- EXEC:
  - cmd_ready=0.
  - If counter≠0, decrement it.
  - If counter=0, AC←alu_result, rsp_data←alu_result, rsp_err←0, go to RESP.
- RESP:
  - rsp_valid=1; cmd_ready=0.
  - On an edge with rsp_ready=1, go to IDLE; rsp_valid falls in the same cycle that IDLE is entered.
  - rsp_data and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
- alu_bus, alu_ac and alu_op are registered outputs. They hold their last values between commands, so ALU inputs never glitch.
- Arithmetic is entirely inside the ALU. The driver only captures the WIDTH-bit result, so any overflow or truncation is the ALU's.
- cmd_load takes priority over cmd_op, and op legality is not checked when cmd_load=1.

## Timing
- Command accepted at edge k:
  - ALU op: alu_* valid after edge k. Result sampled at edge k+SETTLE. rsp_valid=1 and ac_out updated after edge k+SETTLE.
  - Load or illegal op: rsp_valid=1 after edge k.
- Response consumed at edge r: cmd_ready=1 after edge r. The earliest next accept is at edge r+1.
- With rsp_ready tied high, throughput is one ALU op per SETTLE+2 cycles, and one load per 2 cycles.
- busy is high from the cycle after acceptance until the cycle after the response handshake.
- Reset asserted in EXEC or RESP aborts immediately. The pending response is lost and all outputs take their reset values.

## Test plan
- Bench ALU model for ops 0..5. Load cmd_data=5 → rsp_data=5, ac_out=5, rsp_err=0. Then ops 0..5 with cmd_data=2, reloading AC=5 before each → rsp_data equals the model result of (bus=2, AC=5, op), ac_out matches, and alu_bus=2, alu_ac=5 during EXEC.
- SETTLE=3, op with rsp_ready=1 → rsp_valid rises exactly 3 edges after acceptance. cmd_ready is 0 throughout EXEC and RESP and returns 1 the cycle after the response handshake.
- AC=5, cmd_op=6 → rsp_err=1, rsp_data=5, ac_out stays 5, and alu_op keeps its previous value.
- rsp_ready held low for 5 cycles in RESP → rsp_valid, rsp_data and rsp_err stable, cmd_ready=0. A cmd_valid pulse during this window is not accepted.
- Chained ops without reload: load 5, then op with bus=2, then another op with bus=2 → the second op's alu_ac equals the first op's result.
- rst_n pulsed low during EXEC (SETTLE=3) → outputs go to their reset values asynchronously, no response is issued, and a new load of 7 after reset completes with rsp_data=7.
